// File: rtl/mxint8_block_collector_pkg.sv
// mxint8_block_collector_pkg
//   Shared constants and types for the MXINT8 block collector.
//   The element/scale widths and the default block size come from the
//   MXINT8 shared defines below. Each define is only set here if the
//   including build has not already set it.
//   Contents:
//     SCALE_WIDTH, ELEMENT_WIDTH, DEFAULT_BLOCK_SIZE  - widths and sizes
//     collector_state_t                              - collector FSM states
//     beat_index_width()                             - beat counter width

`ifndef SCALE_WIDTH
`define SCALE_WIDTH 8
`endif
`ifndef MXINT8_ELEMENT_WIDTH
`define MXINT8_ELEMENT_WIDTH 8
`endif
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif
// Reserved MXINT8 element code. The collector passes it through untouched.
`ifndef MXINT8_UNUSED_CODE
`define MXINT8_UNUSED_CODE 8'h80
`endif

package mxint8_block_collector_pkg;

    localparam int SCALE_WIDTH        = `SCALE_WIDTH;
    localparam int ELEMENT_WIDTH      = `MXINT8_ELEMENT_WIDTH;
    localparam int DEFAULT_BLOCK_SIZE = `BLOCK_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } collector_state_t;

    // The beat counter must be at least one bit wide, even when a block is
    // a single beat.
    function automatic int beat_index_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/mxint8_block_collector_if.sv
// mxint8_block_collector_if
//   Groups the narrow input beat stream and the wide block output stream.
//   Input stream  : i_valid / o_ready, i_first, i_scale, i_elements (LANES)
//   Output stream : o_valid / i_ready, o_scale, o_mxint8_elements (BLOCK_SIZE)
//   Modports:
//     master - the environment, which drives beats and accepts blocks
//     slave  - the collector

interface mxint8_block_collector_if
    import mxint8_block_collector_pkg::*;
#(
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int LANES      = 4
) ();

    logic                                     i_valid;
    logic                                     o_ready;
    logic                                     i_first;
    logic [SCALE_WIDTH-1:0]                   i_scale;
    logic [LANES-1:0][ELEMENT_WIDTH-1:0]      i_elements;

    logic                                     o_valid;
    logic                                     i_ready;
    logic [SCALE_WIDTH-1:0]                   o_scale;
    logic [BLOCK_SIZE-1:0][ELEMENT_WIDTH-1:0] o_mxint8_elements;

    modport master (
        output i_valid, i_first, i_scale, i_elements, i_ready,
        input  o_ready, o_valid, o_scale, o_mxint8_elements
    );

    modport slave (
        input  i_valid, i_first, i_scale, i_elements, i_ready,
        output o_ready, o_valid, o_scale, o_mxint8_elements
    );

endinterface

// File: rtl/mxint8_block_buffer.sv
// mxint8_block_buffer
//   Storage for one MXINT8 block: a scale register, BLOCK_SIZE element
//   registers written LANES at a time at a beat offset, and a full flag.
//   Ports:
//     i_clk, i_rst          clock, asynchronous active-high reset
//     wr_en, wr_beat        write wr_lanes into elements [wr_beat*LANES +: LANES]
//     wr_lanes              lane data for the write
//     scale_en, wr_scale    capture a new block scale
//     set_full, clr_full    mark the block complete / released (set wins)
//     scale, elements, full stored block and its full flag

module mxint8_block_buffer
    import mxint8_block_collector_pkg::*;
#(
    parameter  int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter  int LANES      = 4,
    localparam int BEATS      = BLOCK_SIZE / LANES,
    localparam int BW         = beat_index_width(BEATS)
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic                                     wr_en,
    input  logic [BW-1:0]                            wr_beat,
    input  logic [LANES-1:0][ELEMENT_WIDTH-1:0]      wr_lanes,
    input  logic                                     scale_en,
    input  logic [SCALE_WIDTH-1:0]                   wr_scale,
    input  logic                                     set_full,
    input  logic                                     clr_full,
    output logic [SCALE_WIDTH-1:0]                   scale,
    output logic [BLOCK_SIZE-1:0][ELEMENT_WIDTH-1:0] elements,
    output logic                                     full
);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scale    <= '0;
            elements <= '0;
            full     <= 1'b0;
        end else begin
            if (scale_en) begin
                scale <= wr_scale;
            end
            // Compare against every beat so each element index is a constant.
            if (wr_en) begin
                for (int b = 0; b < BEATS; b++) begin
                    if (wr_beat == BW'(b)) begin
                        for (int k = 0; k < LANES; k++) begin
                            elements[b*LANES + k] <= wr_lanes[k];
                        end
                    end
                end
            end
            // A buffer refilled in the cycle it is released ends up full again.
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mxint8_block_collector.sv
// mxint8_block_collector
//   Collects a narrow MXINT8 stream (LANES elements per beat, scale on the
//   first beat) into complete BLOCK_SIZE-element blocks. Each block is
//   presented in parallel on a valid/ready interface. The collector flags
//   framing errors and counts delivered blocks.
//   Ports:
//     i_clk, i_rst    clock, asynchronous active-high reset
//     bus (slave)     beat input stream and block output stream
//     o_sync_err      one-cycle pulse after a framing error
//     o_block_count   number of delivered blocks, wraps
//   Build option:
//     MXINT8_COLLECT_PINGPONG_EN - two buffers, filled alternately and
//     delivered in arrival order. This sustains one beat per cycle across
//     block boundaries. Without it the collector uses one buffer.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | beat counter 0, waiting for a first beat
//   ST_FILL | 0 < counter < BEATS, block partially written
//   ST_FULL | block held for downstream (single-buffer build)

module mxint8_block_collector
    import mxint8_block_collector_pkg::*;
#(
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
    parameter int LANES      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mxint8_block_collector_if.slave bus,
    output logic                 o_sync_err,
    output logic [CNT_WIDTH-1:0] o_block_count
);

    localparam int BEATS = BLOCK_SIZE / LANES;
    localparam int BW    = beat_index_width(BEATS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

`ifdef MXINT8_COLLECT_PINGPONG_EN
    localparam int NBUF = 2;
    // Completed blocks live in the buffer full flags, so writing returns to idle.
    localparam collector_state_t DONE_STATE = ST_IDLE;
`else
    localparam int NBUF = 1;
    localparam collector_state_t DONE_STATE = ST_FULL;
`endif

    if (BLOCK_SIZE % LANES != 0) begin : g_bad_lanes
        $error("BLOCK_SIZE must be a multiple of LANES");
    end

    collector_state_t state, state_nxt;
    logic [BW-1:0]    cnt, cnt_nxt, wr_beat;
    logic             ready_en;
    logic             accept, deliver;
    logic             wr_en, scale_en, set_full, err_nxt;
    logic             wr_sel, rd_sel;

    logic [NBUF-1:0]                          buf_full;
    logic [SCALE_WIDTH-1:0]                   buf_scale [NBUF];
    logic [BLOCK_SIZE-1:0][ELEMENT_WIDTH-1:0] buf_elems [NBUF];

    assign accept  = bus.i_valid && bus.o_ready;
    assign deliver = bus.o_valid && bus.i_ready;

    assign bus.o_valid           = buf_full[rd_sel];
    assign bus.o_scale           = buf_scale[rd_sel];
    assign bus.o_mxint8_elements = buf_elems[rd_sel];

`ifdef MXINT8_COLLECT_PINGPONG_EN
    // The write target can be released and rewritten in the same cycle. This
    // is what removes the bubble between back-to-back blocks.
    assign bus.o_ready = ready_en && (!buf_full[wr_sel] || (deliver && (rd_sel == wr_sel)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (set_full) wr_sel <= ~wr_sel;
            if (deliver)  rd_sel <= ~rd_sel;
        end
    end
`else
    assign bus.o_ready = ready_en && (state != ST_FULL);
    assign wr_sel      = 1'b0;
    assign rd_sel      = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ready_en      <= 1'b0;
            o_sync_err    <= 1'b0;
            o_block_count <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ready_en   <= 1'b1;
            o_sync_err <= err_nxt;
            if (deliver) begin
                o_block_count <= o_block_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wr_en     = 1'b0;
        scale_en  = 1'b0;
        set_full  = 1'b0;
        err_nxt   = 1'b0;
        wr_beat   = bus.i_first ? '0 : cnt;
        case (state)
            ST_IDLE, ST_FILL: begin
                if (accept) begin
                    if (bus.i_first) begin
                        // A restart abandons the partial block. The new
                        // block's beats overwrite all of its stale lanes.
                        scale_en = 1'b1;
                        wr_en    = 1'b1;
                        err_nxt  = (cnt != '0);
                        if (BEATS == 1) begin
                            set_full  = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = DONE_STATE;
                        end else begin
                            cnt_nxt   = BW'(1);
                            state_nxt = ST_FILL;
                        end
                    end else if (cnt == '0) begin
                        err_nxt = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                        if (cnt == LAST_BEAT) begin
                            set_full  = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = DONE_STATE;
                        end else begin
                            cnt_nxt   = cnt + BW'(1);
                            state_nxt = ST_FILL;
                        end
                    end
                end
            end
            ST_FULL: begin
                if (deliver) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    for (genvar i = 0; i < NBUF; i++) begin : g_buf
        mxint8_block_buffer #(
            .BLOCK_SIZE (BLOCK_SIZE),
            .LANES      (LANES)
        ) u_buf (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .wr_en    (wr_en && (wr_sel == 1'(i))),
            .wr_beat  (wr_beat),
            .wr_lanes (bus.i_elements),
            .scale_en (scale_en && (wr_sel == 1'(i))),
            .wr_scale (bus.i_scale),
            .set_full (set_full && (wr_sel == 1'(i))),
            .clr_full (deliver && (rd_sel == 1'(i))),
            .scale    (buf_scale[i]),
            .elements (buf_elems[i]),
            .full     (buf_full[i])
        );
    end

endmodule

// File: tb/tb_mxint8_block_collector.sv
// tb_mxint8_block_collector
//   Self-checking bench for mxint8_block_collector (LANES=4, BLOCK_SIZE=32).
//   The reference model rebuilds blocks from accepted beats using the framing
//   rules and keeps a queue of blocks owed downstream.

module tb_mxint8_block_collector;
    import mxint8_block_collector_pkg::*;

    localparam int BS    = 32;
    localparam int LN    = 4;
    localparam int BEATS = BS / LN;
    localparam int CW    = 16;
`ifdef MXINT8_COLLECT_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    typedef logic [LN-1:0][7:0] lanes_t;
    typedef struct packed {
        logic [7:0]         scale;
        logic [BS-1:0][7:0] el;
    } blk_t;
    typedef struct packed {
        bit          acc;
        bit          del;
        bit          ready;
        bit          rdy_in;
        int unsigned qsz;
        bit          have_exp;
        blk_t        got;
        blk_t        exp;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          sync_err;
    logic [CW-1:0] block_count;

    mxint8_block_collector_if #(.BLOCK_SIZE(BS), .LANES(LN)) bus ();

    mxint8_block_collector #(.BLOCK_SIZE(BS), .LANES(LN), .CNT_WIDTH(CW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .bus           (bus.slave),
        .o_sync_err    (sync_err),
        .o_block_count (block_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    blk_t m_cur;
    int   m_beat;
    bit   m_err;
    int   m_count;
    blk_t exp_q[$];

    task automatic model_reset();
        m_cur   = '0;
        m_beat  = 0;
        m_err   = 1'b0;
        m_count = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input bit first, input logic [7:0] sc, input lanes_t ln);
        if (first) begin
            m_err       = (m_beat != 0);
            m_cur.scale = sc;
            m_beat      = 0;
        end else if (m_beat == 0) begin
            m_err = 1'b1;
            return;
        end
        for (int k = 0; k < LN; k++) m_cur.el[m_beat*LN + k] = ln[k];
        m_beat++;
        if (m_beat == BEATS) begin
            exp_q.push_back(m_cur);
            m_beat = 0;
        end
    endtask

    function automatic lanes_t rand_lanes();
        lanes_t r;
        for (int k = 0; k < LN; k++) r[k] = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
        return r;
    endfunction

    function automatic logic [7:0] rand_scale();
        return ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
    endfunction

    task automatic drive(input bit v, input bit f, input logic [7:0] sc, input lanes_t ln);
        bus.i_valid    = v;
        bus.i_first    = f;
        bus.i_scale    = sc;
        bus.i_elements = ln;
    endtask

    // One clock: observe at the falling edge, update the model, return at
    // posedge+1.
    task automatic cycle(output obs_t o);
        o = '0;
        @(negedge clk);
        o.acc       = bus.i_valid && bus.o_ready;
        o.ready     = bus.o_ready;
        o.rdy_in    = bus.i_ready;
        o.del       = bus.o_valid && bus.i_ready;
        o.qsz       = exp_q.size();
        o.got.scale = bus.o_scale;
        o.got.el    = bus.o_mxint8_elements;
        m_err = 1'b0;
        if (o.del) begin
            m_count++;
            o.have_exp = (exp_q.size() != 0);
            if (o.have_exp) o.exp = exp_q.pop_front();
        end
        if (o.acc) model_accept(bus.i_first, bus.i_scale, bus.i_elements);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_reset();
        drive(1'b0, 1'b0, 8'h00, '0);
        bus.i_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 8'h00, '0);
        bus.i_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.o_ready); end
        checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.o_valid); end
        checks++; if (block_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", block_count); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
        checks++; if (bus.o_scale !== 8'h00) begin errors++; $display("FAIL reset_scale: got %0h want 0", bus.o_scale); end
        checks++; if (bus.o_mxint8_elements !== '0) begin errors++; $display("FAIL reset_elements: got %0h want 0", bus.o_mxint8_elements); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.o_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        obs_t o;
        lanes_t ln;
        logic [BS-1:0][7:0] ev;
        bus.i_ready = 1'b1;
        for (int b = 0; b < BEATS; b++) begin
            for (int k = 0; k < LN; k++) ln[k] = 8'(b*LN + k);
            drive(1'b1, b == 0, 8'd127, ln);
            cycle(o);
            checks++; if (o.acc !== 1'b1) begin errors++; $display("FAIL basic_accept beat %0d: got %b want 1", b, o.acc); end
            checks++; if (bus.o_valid !== (b == BEATS-1)) begin errors++; $display("FAIL basic_valid_latency beat %0d: got %b want %b", b, bus.o_valid, b == BEATS-1); end
        end
        drive(1'b0, 1'b0, 8'h00, '0);
        for (int i = 0; i < BS; i++) ev[i] = 8'(i);
        checks++; if (bus.o_scale !== 8'd127) begin errors++; $display("FAIL basic_scale: got %0d want 127", bus.o_scale); end
        checks++; if (bus.o_mxint8_elements !== ev) begin errors++; $display("FAIL basic_elements: got %0h want %0h", bus.o_mxint8_elements, ev); end
        cycle(o);
        checks++; if (!(o.del && o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL basic_delivery: del %b got %0h want %0h", o.del, o.got, o.exp); end
        checks++; if (block_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d want 1", block_count); end
        checks++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL basic_after_delivery: ready %b valid %b want 1 0", bus.o_ready, bus.o_valid); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        logic [7:0] sc;
        sc = rand_scale();
        bus.i_ready = 1'b0;
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, b == 0, sc, rand_lanes());
            cycle(o);
            checks++; if (o.acc !== 1'b1) begin errors++; $display("FAIL bp_accept beat %0d: got %b want 1", b, o.acc); end
        end
        drive(1'b0, 1'b0, 8'h00, '0);
        for (int c = 0; c < 5; c++) begin
            cycle(o);
            checks++; if (o.ready !== PP) begin errors++; $display("FAIL bp_ready cycle %0d: got %b want %b", c, o.ready, PP); end
            checks++; if (o.got !== exp_q[0] || bus.o_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cycle %0d: valid %b got %0h want %0h", c, bus.o_valid, o.got, exp_q[0]); end
        end
        bus.i_ready = 1'b1;
        cycle(o);
        checks++; if (!(o.del && o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL bp_delivery: del %b got %0h want %0h", o.del, o.got, o.exp); end
        checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b want 1", bus.o_ready); end
        checks++; if (block_count !== CW'(m_count)) begin errors++; $display("FAIL bp_count: got %0d want %0d", block_count, m_count); end
    endtask

    task automatic test_restart();
        obs_t o;
        logic [7:0] sc;
        sc = rand_scale();
        bus.i_ready = 1'b1;
        for (int b = 0; b < 3 + BEATS; b++) begin
            if (b < 3) drive(1'b1, b == 0, sc, rand_lanes());
            else       drive(1'b1, b == 3, 8'd10, rand_lanes());
            cycle(o);
            checks++; if (sync_err !== m_err || sync_err !== (b == 3)) begin errors++; $display("FAIL restart_sync_err beat %0d: got %b want %b", b, sync_err, b == 3); end
        end
        drive(1'b0, 1'b0, 8'h00, '0);
        cycle(o);
        checks++; if (!(o.del && o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL restart_delivery: del %b got %0h want %0h", o.del, o.got, o.exp); end
        checks++; if (o.got.scale !== 8'd10) begin errors++; $display("FAIL restart_scale: got %0d want 10", o.got.scale); end
        cycle(o);
        checks++; if (bus.o_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL restart_no_extra_block: valid %b queued %0d want 0 0", bus.o_valid, exp_q.size()); end
    endtask

    task automatic test_idle_drop();
        obs_t o;
        int cnt0;
        cnt0 = m_count;
        bus.i_ready = 1'b1;
        drive(1'b1, 1'b0, 8'h55, rand_lanes());
        cycle(o);
        checks++; if (o.acc !== 1'b1 || sync_err !== 1'b1) begin errors++; $display("FAIL drop_sync_err: acc %b err %b want 1 1", o.acc, sync_err); end
        drive(1'b0, 1'b0, 8'h00, '0);
        cycle(o);
        checks++; if (sync_err !== 1'b0 || bus.o_valid !== 1'b0) begin errors++; $display("FAIL drop_pulse_width: err %b valid %b want 0 0", sync_err, bus.o_valid); end
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, b == 0, rand_scale(), rand_lanes());
            cycle(o);
        end
        drive(1'b0, 1'b0, 8'h00, '0);
        cycle(o);
        checks++; if (!(o.del && o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL drop_next_block: del %b got %0h want %0h", o.del, o.got, o.exp); end
        checks++; if (block_count !== CW'(cnt0 + 1)) begin errors++; $display("FAIL drop_count: got %0d want %0d", block_count, cnt0 + 1); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        bus.i_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            drive(1'b1, b == 0, rand_scale(), rand_lanes());
            cycle(o);
        end
        drive(1'b1, 1'b0, 8'h00, rand_lanes());
        rst = 1'b1;
        model_reset();
        #1;
        checks++; if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin errors++; $display("FAIL midrst_handshake: valid %b ready %b want 0 0", bus.o_valid, bus.o_ready); end
        checks++; if (block_count !== '0) begin errors++; $display("FAIL midrst_count: got %0d want 0", block_count); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, '0);
        @(posedge clk);
        #1;
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, b == 0, rand_scale(), rand_lanes());
            cycle(o);
            checks++; if (o.acc !== 1'b1) begin errors++; $display("FAIL midrst_accept beat %0d: got %b want 1", b, o.acc); end
        end
        drive(1'b0, 1'b0, 8'h00, '0);
        cycle(o);
        checks++; if (!(o.del && o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL midrst_delivery: del %b got %0h want %0h", o.del, o.got, o.exp); end
        checks++; if (block_count !== 16'd1) begin errors++; $display("FAIL midrst_count_after: got %0d want 1", block_count); end
    endtask

    task automatic test_random();
        obs_t o;
        bit v, f, exp_rdy;
        for (int c = 0; c < 400 + 12; c++) begin
            v = (c < 400) && ($urandom_range(0, 9) < 8);
            if (m_beat == 0) f = ($urandom_range(0, 19) != 0);
            else             f = ($urandom_range(0, 29) == 0);
            drive(v, f, rand_scale(), rand_lanes());
            bus.i_ready = (c >= 400) || ($urandom_range(0, 9) < 6);
            cycle(o);
            exp_rdy = PP ? ((o.qsz < 2) || o.rdy_in) : (o.qsz == 0);
            checks++; if (o.ready !== exp_rdy) begin errors++; $display("FAIL rand_ready cycle %0d: got %b want %b", c, o.ready, exp_rdy); end
            checks++; if (sync_err !== m_err) begin errors++; $display("FAIL rand_sync_err cycle %0d: got %b want %b", c, sync_err, m_err); end
            checks++; if (bus.o_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid cycle %0d: got %b want %b", c, bus.o_valid, exp_q.size() != 0); end
            checks++; if (block_count !== CW'(m_count)) begin errors++; $display("FAIL rand_count cycle %0d: got %0d want %0d", c, block_count, m_count); end
            if (o.del) begin
                checks++; if (!(o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL rand_block cycle %0d: got %0h want %0h", c, o.got, o.exp); end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        lanes_t beats[BS];
        logic [7:0] scales[4];
        int idx, cyc, ndel;
        quiet_reset();
        for (int i = 0; i < 4; i++) scales[i] = rand_scale();
        for (int i = 0; i < BS; i++) beats[i] = rand_lanes();
        idx = 0;
        cyc = 0;
        ndel = 0;
        while (idx < BS && cyc < 100) begin
            drive(1'b1, (idx % BEATS) == 0, scales[idx / BEATS], beats[idx]);
            cycle(o);
            cyc++;
            if (o.acc) idx++;
            if (o.del) begin
                ndel++;
                checks++; if (!(o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL b2b_block %0d: got %0h want %0h", ndel, o.got, o.exp); end
            end
        end
        checks++; if (idx != BS) begin errors++; $display("FAIL b2b_budget: accepted %0d want %0d", idx, BS); end
        checks++; if (cyc != (PP ? BS : BS + 3)) begin errors++; $display("FAIL b2b_cycles: got %0d want %0d", cyc, PP ? BS : BS + 3); end
        drive(1'b0, 1'b0, 8'h00, '0);
        for (int c = 0; c < 10; c++) begin
            cycle(o);
            if (o.del) begin
                ndel++;
                checks++; if (!(o.have_exp && o.got === o.exp)) begin errors++; $display("FAIL b2b_block %0d: got %0h want %0h", ndel, o.got, o.exp); end
            end
        end
        checks++; if (block_count !== 16'd4 || ndel != 4) begin errors++; $display("FAIL b2b_count: got %0d delivered %0d want 4", block_count, ndel); end
        checks++; if (bus.o_valid !== 1'b0 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_drained: valid %b queued %0d want 0 0", bus.o_valid, exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_restart();
        test_idle_drop();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mxint8_block_collector.md
Name: mxint8_block_collector

Overview:
- Upstream feeder of the MXINT8 block-sum stage.
- Accepts a narrow MXINT8 stream of LANES elements per beat, with the shared scale on the first beat.
- Assembles complete BLOCK_SIZE-element blocks and presents each block in parallel (scale plus all elements) on a valid/ready interface, directly matching the sum stage's inputs.
- Detects stream framing errors and counts delivered blocks.

Parameters:
- BLOCK_SIZE, default `BLOCK_SIZE (32): elements per MX block.
- LANES, default 4: elements accepted per input beat. BLOCK_SIZE % LANES must be 0 (elaboration-time check).
- CNT_WIDTH, default 16: width of the delivered-block counter.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous active-high reset
- i_valid  in  1  input beat valid
- o_ready  out  1  collector can accept a beat
- i_first  in  1  beat is beat 0 of a block; i_scale is valid on this beat
- i_scale  in  `SCALE_WIDTH  shared block scale (E8M0)
- i_elements  in  `MXINT8_ELEMENT_WIDTH x LANES  element lanes; lane k maps to block index beat*LANES+k
- o_valid  out  1  assembled block available
- i_ready  in  1  downstream accepts block
- o_scale  out  `SCALE_WIDTH  block scale
- o_mxint8_elements  out  `MXINT8_ELEMENT_WIDTH x BLOCK_SIZE  assembled elements
- o_sync_err  out  1  one-cycle pulse on a framing error
- o_block_count  out  CNT_WIDTH  number of blocks delivered; wraps

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is asynchronous, active-high.
- Reset values: state=IDLE, beat counter=0, o_valid=0, o_sync_err=0, o_block_count=0, o_scale=0, all element registers=0. o_ready=0 while i_rst is high and 1 from the first edge after release.
- BEATS = BLOCK_SIZE/LANES. The beat counter is $clog2(BEATS) bits wide (minimum 1).
- A beat is accepted when i_valid && o_ready. A block is delivered when o_valid && i_ready.
- States:
  - IDLE: counter=0, waiting for beat 0.
  - FILL: 0 < counter < BEATS.
  - FULL: block held.
  - o_ready = (state != FULL).
- Accepted beat with counter==0 and i_first=1: capture i_scale; write lanes 0..LANES-1; counter←1 (state FILL). If BEATS==1, go straight to FULL.
- Accepted beat with counter==0 and i_first=0: drop the beat, pulse o_sync_err, stay IDLE.
- Accepted beat with counter!=0 and i_first=1: abandon the partial block; treat this beat as the new beat 0 (scale captured, counter←1); pulse o_sync_err.
- Accepted beat with counter==BEATS-1 and i_first=0: write the final lanes, counter←0, state←FULL.
  - o_valid rises the next cycle. Latency is 1 cycle from the last-beat accept to o_valid.
- FULL with i_ready=1: deliver, state←IDLE, o_block_count+1 (modulo 2^CNT_WIDTH).
  - o_ready returns high the following cycle. There is no same-cycle refill in the base build.
- While o_valid=1, o_scale and o_mxint8_elements are stable until delivery. o_valid never deasserts without a handshake.
- Element values pass through unmodified, including 8'b1000_0000 and scale 8'hFF. Interpretation of those values belongs to the downstream stage.
- i_rst mid-fill or mid-FULL: the partial or held block is discarded and every register returns to its reset value.

Optional Feature:
- Macro: MXINT8_COLLECT_PINGPONG_EN.
- When defined: two block buffers, written alternately and delivered in arrival order.
  - o_ready = at least one buffer not FULL.
  - A buffer freed by delivery is writable the same cycle, so back-to-back blocks sustain one beat per cycle with no bubble.
  - Framing-error rules apply per buffer being filled.
- When undefined: single buffer, behaviour exactly as above. At full input rate there is at least one idle cycle per block.

Decomposition:
- Shared constants stay in mxint8_includes.v / scalar_includes.v: `SCALE_WIDTH, `MXINT8_ELEMENT_WIDTH, `BLOCK_SIZE. Add `MXINT8_UNUSED_CODE (8'h80) there.
- One natural sub-module: mxint8_block_buffer.
  - Contents: scale register, BLOCK_SIZE element registers, lane-indexed write at a beat offset, full flag.
  - Instantiated once, or twice under MXINT8_COLLECT_PINGPONG_EN.
  - FSM, counter and handshake logic stay in the top module.

Test Plan (LANES=4, BLOCK_SIZE=32, BEATS=8):
- Reset then 8 consecutive beats (first beat i_first=1, i_scale=8'd127, elements 0..31), i_ready=1 → o_valid high the cycle after beat 7; o_scale=127; o_mxint8_elements[i]=i; o_block_count=1 after delivery.
- Same block with i_ready=0 for 5 cycles → o_ready=0 and outputs stable throughout; one delivery on i_ready rise; o_ready=1 the next cycle.
- i_first=1 on beat 3 of a block (new scale 8'd10) → one o_sync_err pulse; delivered block has scale 10 and elements from the restart beat onward; no block from the abandoned data.
- Beat with i_first=0 while IDLE → o_sync_err pulse, beat dropped, next i_first=1 beat starts a block normally.
- Assert i_rst at beat 5 for one cycle → o_valid=0, count=0, o_ready=0 during reset; a fresh 8-beat block afterwards delivers correctly.
- PINGPONG_EN: 4 blocks streamed back-to-back with i_ready=1 → 32 accepts in 32 cycles with no o_ready drop; blocks delivered in order; o_block_count=4.
